// File: rtl/apb_rr_arbiter_pkg.sv
// Shared types and default sizing for the two-requester APB round-robin arbiter.
package apb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/apb_rr_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last-grant pointer advances only when a grant is issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       arb_en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic last_q;
  logic last_d;

  // Ties go to the requester that was not served last.
  always_comb begin
    gnt_idx = req[1];
    if (req == 2'b11) gnt_idx = ~last_q;
    gnt    = 2'b00;
    last_d = last_q;
    if (arb_en && (req != 2'b00)) begin
      gnt    = gnt_idx ? 2'b10 : 2'b01;
      last_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Arbitrates two command ports onto one APB master with round-robin grant and ACCESS timeout.
module apb_rr_arbiter
  import apb_rr_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]     req_wdata,
  input  logic [2*(DATA_W/8)-1:0] req_strb,
  input  logic [5:0]              req_prot,
  output logic [1:0]              rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [ADDR_W-1:0]       PADDR,
  output logic                    PWRITE,
  output logic [DATA_W-1:0]       PWDATA,
  output logic [DATA_W/8-1:0]     PSTRB,
  output logic [2:0]              PPROT,
  input  logic [DATA_W-1:0]       PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  apb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [2:0]          prot_q, prot_d;
  logic [7:0]          wait_q, wait_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                arb_en;
  logic [1:0]          gnt;
  logic                gnt_idx;
  logic                accept;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_strb;
  logic [2:0]          sel_prot;

  assign arb_en = (state_q == IDLE) || ((state_q == ACCESS) && PREADY);
  assign accept = |gnt;

  rr_arb2 u_arb (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .req     (req_valid),
    .arb_en  (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign sel_write = gnt_idx ? req_write[1] : req_write[0];
  assign sel_addr  = gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
  assign sel_wdata = gnt_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign sel_strb  = gnt_idx ? req_strb[2*STRB_W-1:STRB_W]  : req_strb[STRB_W-1:0];
  assign sel_prot  = gnt_idx ? req_prot[5:3] : req_prot[2:0];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    prot_d      = prot_q;
    wait_d      = wait_q;
    rsp_valid_d = 2'b00;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
        wait_d  = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = {owner_q, ~owner_q};
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = write_q ? '0 : PRDATA;
          state_d     = accept ? SETUP : IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
          // The last permitted wait cycle ends the transfer with an error.
          if (wait_q == TO_LAST) begin
            rsp_valid_d = {owner_q, ~owner_q};
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      owner_d = gnt_idx;
      addr_d  = sel_addr;
      write_d = sel_write;
      wdata_d = sel_wdata;
      strb_d  = sel_write ? sel_strb : '0;
      prot_d  = sel_prot;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      prot_q      <= '0;
      wait_q      <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      prot_q      <= prot_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = gnt;
  assign PSEL      = (state_q != IDLE);
  assign PENABLE   = (state_q == ACCESS);
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;
  assign PSTRB     = strb_q;
  assign PPROT     = prot_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Scoreboard bench for apb_rr_arbiter: expected APB setups and responses are queued at issue time.
module tb_apb_rr_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [1:0]      req_valid, req_ready, req_write, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*SW-1:0] req_strb;
  logic [5:0]      req_prot;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA, PRDATA;
  logic [SW-1:0]   PSTRB;
  logic [2:0]      PPROT;

  apb_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
  } apb_exp_t;

  typedef struct packed {
    logic [1:0]    vld;
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_exp_t;

  apb_exp_t exp_apb[$];
  rsp_exp_t exp_rsp[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Slave model: PREADY stays low for wait_n ACCESS cycles, then rises.
  int            wait_n   = 0;
  logic          slv_err  = 1'b0;
  logic [DW-1:0] rdata_val = '0;
  int            acc_done = 0;

  always @(posedge PCLK) acc_done <= (PSEL && PENABLE && !PREADY) ? acc_done + 1 : 0;
  assign PREADY  = PSEL && PENABLE && (acc_done >= wait_n);
  assign PRDATA  = rdata_val;
  assign PSLVERR = slv_err;

  // Monitor
  int       cyc = 0;
  int       acc_len = 0;
  int       last_acc_len = 0;
  int       last_setup_cyc = -1;
  bit       b2b_mode = 1'b0;
  logic     prev_psel = 1'b0;
  logic     psel_at_rsp = 1'b0;
  apb_exp_t cur = '0;
  rsp_exp_t r;

  always @(negedge PCLK) begin
    cyc++;
    if (!b2b_mode) last_setup_cyc = -1;
    if (!PRESETn) begin
      acc_len = 0;
      check("rsp_in_reset", 64'(rsp_valid), 64'(0));
    end else begin
      if (PSEL && !PENABLE) begin
        check("setup_expected", 64'(exp_apb.size() != 0), 64'(1));
        if (exp_apb.size() != 0) begin
          cur = exp_apb.pop_front();
          check("paddr", 64'(PADDR), 64'(cur.addr));
          check("pwrite", 64'(PWRITE), 64'(cur.wr));
          if (cur.wr) check("pwdata", 64'(PWDATA), 64'(cur.wdata));
          check("pstrb", 64'(PSTRB), 64'(cur.strb));
          check("pprot", 64'(PPROT), 64'(cur.prot));
        end
        if (b2b_mode && last_setup_cyc >= 0) check("b2b_gap", 64'(cyc - last_setup_cyc), 64'(2));
        last_setup_cyc = cyc;
      end
      if (PSEL && PENABLE) begin
        check("enable_after_setup", 64'(prev_psel), 64'(1));
        check("access_hold_addr", 64'(PADDR), 64'(cur.addr));
        acc_len++;
        if (PREADY) begin
          last_acc_len = acc_len;
          acc_len = 0;
        end
      end else if (!PSEL && acc_len != 0) begin
        last_acc_len = acc_len;
        acc_len = 0;
      end
      if (rsp_valid != 2'b00) begin
        psel_at_rsp = PSEL;
        check("rsp_expected", 64'(exp_rsp.size() != 0), 64'(1));
        if (exp_rsp.size() != 0) begin
          r = exp_rsp.pop_front();
          check("rsp_valid", 64'(rsp_valid), 64'(r.vld));
          check("rsp_err", 64'(rsp_err), 64'(r.err));
          check("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
        end
      end
    end
    prev_psel = PSEL;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic drive_cmd(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [2:0] p);
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_strb[i*SW +: SW]  = s;
    req_prot[i*3 +: 3]    = p;
  endtask

  task automatic expect_apb(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input logic [2:0] p);
    apb_exp_t e;
    e.addr  = a;
    e.wr    = wr;
    e.wdata = d;
    e.strb  = wr ? s : '0;
    e.prot  = p;
    exp_apb.push_back(e);
  endtask

  task automatic expect_rsp(input int i, input logic err, input logic [DW-1:0] rd);
    rsp_exp_t e;
    e.vld   = (i == 0) ? 2'b01 : 2'b10;
    e.err   = err;
    e.rdata = rd;
    exp_rsp.push_back(e);
  endtask

  // Assert req_valid[i], wait (bounded) for its ready, drop valid after the accepting edge.
  task automatic issue(input int i, input string tag);
    int k = 0;
    req_valid[i] = 1'b1;
    #1;
    while (!req_ready[i] && k < 100) begin
      @(negedge PCLK);
      #1;
      k++;
    end
    check(tag, 64'(req_ready[i]), 64'(1));
    @(posedge PCLK);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp_drain(input string tag);
    int k = 0;
    while (exp_rsp.size() != 0 && k < 200) begin
      @(negedge PCLK);
      k++;
    end
    check(tag, 64'(exp_rsp.size()), 64'(0));
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_acc;
    int k;
    PRESETn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    tick(2);
    check("rst_psel", 64'(PSEL), 64'(0));
    check("rst_penable", 64'(PENABLE), 64'(0));
    check("rst_paddr", 64'(PADDR), 64'(0));
    check("rst_pwdata", 64'(PWDATA), 64'(0));
    check("rst_pstrb_pprot_pwrite", 64'({PSTRB, PPROT, PWRITE}), 64'(0));
    check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    PRESETn = 1'b1;
    tick(1);

    // Single write from requester 0, zero wait states.
    wait_n = 0;
    drive_cmd(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000);
    expect_apb(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000);
    expect_rsp(0, 1'b0, 32'h0);
    issue(0, "wr_ready");
    wait_rsp_drain("wr_done");
    check("wr_access_len", 64'(last_acc_len), 64'(1));

    // Single read from requester 1 with three wait states; strobes must not leak.
    wait_n    = 3;
    rdata_val = 32'h12345678;
    drive_cmd(1, 1'b0, 32'h20, 32'h55, 4'hF, 3'b010);
    expect_apb(1'b0, 32'h20, 32'h55, 4'hF, 3'b010);
    expect_rsp(1, 1'b0, 32'h12345678);
    issue(1, "rd_ready");
    wait_rsp_drain("rd_done");
    check("rd_access_len", 64'(last_acc_len), 64'(4));
    check("idle_holds_paddr", 64'(PADDR), 64'(32'h20));

    // Contention: both valid for four transfers, expect 0,1,0,1 back to back.
    wait_n    = 0;
    rdata_val = 32'hCAFEF00D;
    drive_cmd(0, 1'b1, 32'h100, 32'h11111111, 4'h3, 3'b001);
    drive_cmd(1, 1'b0, 32'h200, 32'h22222222, 4'hC, 3'b101);
    for (int t = 0; t < 2; t++) begin
      expect_apb(1'b1, 32'h100, 32'h11111111, 4'h3, 3'b001);
      expect_apb(1'b0, 32'h200, 32'h22222222, 4'hC, 3'b101);
      expect_rsp(0, 1'b0, 32'h0);
      expect_rsp(1, 1'b0, 32'hCAFEF00D);
    end
    b2b_mode  = 1'b1;
    req_valid = 2'b11;
    #1;
    n_acc = 0;
    k = 0;
    while (n_acc < 4 && k < 200) begin
      if (req_ready != 2'b00) n_acc++;
      if (n_acc < 4) begin
        @(negedge PCLK);
        #1;
        k++;
      end
    end
    check("contention_accepts", 64'(n_acc), 64'(4));
    @(posedge PCLK);
    #1;
    req_valid = 2'b00;
    wait_rsp_drain("contention_done");
    b2b_mode = 1'b0;

    // Timeout: slave never ready; read data must be zeroed on abort.
    wait_n    = 1000;
    rdata_val = 32'hAAAA5555;
    drive_cmd(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b100);
    expect_apb(1'b0, 32'h40, 32'h0, 4'h0, 3'b100);
    expect_rsp(0, 1'b1, 32'h0);
    issue(0, "to_ready");
    wait_rsp_drain("to_done");
    check("to_access_len", 64'(last_acc_len), 64'(16));
    check("to_psel_at_rsp", 64'(psel_at_rsp), 64'(0));
    check("to_idle_after", 64'({PSEL, PENABLE}), 64'(0));

    // Slave error on requester 1, then a clean read on requester 0.
    wait_n  = 0;
    slv_err = 1'b1;
    drive_cmd(1, 1'b1, 32'h80, 32'hA5A5A5A5, 4'h5, 3'b111);
    expect_apb(1'b1, 32'h80, 32'hA5A5A5A5, 4'h5, 3'b111);
    expect_rsp(1, 1'b1, 32'h0);
    issue(1, "err_ready");
    wait_rsp_drain("err_done");
    slv_err   = 1'b0;
    rdata_val = 32'h0BADCAFE;
    drive_cmd(0, 1'b0, 32'h84, 32'h0, 4'h0, 3'b000);
    expect_apb(1'b0, 32'h84, 32'h0, 4'h0, 3'b000);
    expect_rsp(0, 1'b0, 32'h0BADCAFE);
    issue(0, "ok_ready");
    wait_rsp_drain("ok_done");

    // Reset in the middle of ACCESS: transfer dropped, requester 0 wins the next tie.
    wait_n = 1000;
    drive_cmd(0, 1'b1, 32'h300, 32'h33333333, 4'hF, 3'b000);
    expect_apb(1'b1, 32'h300, 32'h33333333, 4'hF, 3'b000);
    issue(0, "rst_mid_ready");
    k = 0;
    while (!(PSEL && PENABLE) && k < 20) begin
      @(negedge PCLK);
      k++;
    end
    check("rst_mid_in_access", 64'({PSEL, PENABLE}), 64'(2'b11));
    tick(2);
    #2;
    PRESETn = 1'b0;
    #1;
    check("rst_mid_psel_penable", 64'({PSEL, PENABLE}), 64'(0));
    tick(2);
    PRESETn = 1'b1;
    wait_n  = 0;
    tick(1);
    drive_cmd(0, 1'b1, 32'h400, 32'h44444444, 4'h1, 3'b011);
    drive_cmd(1, 1'b1, 32'h500, 32'h55555555, 4'h2, 3'b000);
    expect_apb(1'b1, 32'h400, 32'h44444444, 4'h1, 3'b011);
    expect_rsp(0, 1'b0, 32'h0);
    req_valid = 2'b11;
    #1;
    check("tie_after_reset", 64'(req_ready), 64'(2'b01));
    @(posedge PCLK);
    #1;
    req_valid = 2'b00;
    wait_rsp_drain("post_rst_done");
    check("apb_queue_empty", 64'(exp_apb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/apb_rr_arbiter.md
APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

Interface
- REQ-001 Parameter ADDR_W, default 32, address width of the request ports and PADDR.
- REQ-002 Parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
- REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS wait cycles before abort (range 2..255).
- REQ-004 PCLK  in  1  single clock; all logic is on the rising edge.
- REQ-005 PRESETn  in  1  asynchronous, active-low reset.
- REQ-006 req_valid  in  2  per-requester transfer request; bit i is requester i.
- REQ-007 req_ready  out  2  one-hot acceptance pulse for the granted requester.
- REQ-008 req_write  in  2  per-requester direction: 1 is write, 0 is read.
- REQ-009 req_addr  in  2*ADDR_W  per-requester address, packed; slice i is requester i.
- REQ-010 req_wdata  in  2*DATA_W  per-requester write data, packed.
- REQ-011 req_strb  in  2*DATA_W/8  per-requester byte strobes, packed.
- REQ-012 req_prot  in  6  per-requester 3-bit protection, packed.
- REQ-013 rsp_valid  out  2  one-cycle completion pulse to the owning requester.
- REQ-014 rsp_rdata  out  DATA_W  read data; shared by both requesters, qualified by rsp_valid.
- REQ-015 rsp_err  out  1  error flag, qualified by rsp_valid.
- REQ-016 APB master outputs: PSEL 1, PENABLE 1, PADDR ADDR_W, PWRITE 1, PWDATA DATA_W, PSTRB DATA_W/8, PPROT 3.
- REQ-017 APB master inputs: PRDATA DATA_W, PREADY 1, PSLVERR 1.

Function
- REQ-018 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
- REQ-019 Arbitration occurs in IDLE, and in ACCESS on the completion cycle; if any req_valid is high, the FSM moves to SETUP on the next edge.
- REQ-020 Round-robin: when both requesters are valid, the grant goes to the requester not granted last; a single valid requester always wins.
- REQ-021 req_ready[g] is high combinationally in the arbitration cycle; the command of requester g is registered on that edge.
- REQ-022 SETUP lasts exactly one cycle: PSEL=1, PENABLE=0, with address, control, data and strobes driven from the command register.
- REQ-023 ACCESS: PSEL=1, PENABLE=1, all APB outputs held stable until PREADY=1.
- REQ-024 Completion is ACCESS with PREADY=1: on the next edge rsp_valid[g]=1 for one cycle, rsp_err=PSLVERR, and rsp_rdata=PRDATA for reads or 0 for writes.
- REQ-025 Back-to-back transfers: on completion with a new request pending, the FSM goes directly to SETUP with no IDLE cycle.
- REQ-026 PSTRB SHALL be forced to 0 for read transfers.
- REQ-027 An 8-bit wait counter is cleared on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
- REQ-028 When the wait counter reaches TIMEOUT, the transfer aborts: PSEL=0, rsp_valid[g] pulses with rsp_err=1 and rsp_rdata=0, and the FSM returns to IDLE.
- REQ-029 A requester deasserting req_valid before it receives req_ready is ignored; there is no partial acceptance.
- REQ-030 In IDLE, PSEL=0 and PENABLE=0; PADDR, PWDATA and PSTRB hold their last values.

Reset
- REQ-031 Asserting PRESETn low forces IDLE immediately, from any state including mid-ACCESS; the in-flight transfer is dropped with no rsp_valid.
- REQ-032 Reset values: all outputs 0, wait counter 0, last-grant pointer 1 (so requester 0 wins the first tie).

Structure
- REQ-033 A shared package holds the state enum (IDLE/SETUP/ACCESS) and the default widths and TIMEOUT constants.
- REQ-034 A single sub-module, rr_arb2 (two-way round-robin grant with last-grant register), is instantiated once.

Verification
- REQ-035 Single write: req0 writes 0xDEADBEEF to addr 0x10 with strb 0xF, PREADY tied high -> SETUP then ACCESS on consecutive cycles, then rsp_valid[0] with rsp_err=0.
- REQ-036 Single read: req1 reads addr 0x20, PRDATA=0x12345678, PREADY low for 3 cycles -> ACCESS lasts 4 cycles, rsp_rdata=0x12345678, PSTRB=0.
- REQ-037 Contention: both requesters continuously valid for 4 transfers -> grant order 0,1,0,1 with no IDLE cycles between transfers.
- REQ-038 Timeout: PREADY held low with TIMEOUT=16 -> abort after 16 wait cycles, rsp_err=1, rsp_rdata=0, PSEL=0.
- REQ-039 Slave error: PSLVERR=1 with PREADY=1 -> rsp_err=1 on the owner's rsp_valid pulse only.
- REQ-040 Reset mid-ACCESS: PRESETn low -> PSEL and PENABLE go to 0 immediately, no rsp_valid, and requester 0 wins the next tie.
